// File: rtl/program_sequencer.sv
// Program sequencer: queues run requests, pulses the core start, times each run
// until halt or timeout, and presents the result on a valid/ready port.
module program_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned QDEPTH         = 2
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [7:0]  req_addr,
    output logic        req_ready,
    output logic        start,
    output logic [7:0]  start_addr,
    input  logic        halt,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [7:0]  done_addr,
    output logic [15:0] done_cycles,
    output logic        done_timeout,
    output logic        busy
);

    localparam int unsigned AW = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned OW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [AW-1:0]   q_head;
    logic [AW-1:0]   q_tail;
    logic [OW-1:0]   occ;
    logic [OW-1:0]   occ_n;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            halt_fire;
    logic            timeout_fire;

    // Next-state and per-cycle control decode
    always_comb begin
        state_n      = state;
        pop          = 1'b0;
        halt_fire    = 1'b0;
        timeout_fire = 1'b0;
        push         = req_valid & req_ready;
        case (state)
            IDLE: begin
                if (occ != OW'(0)) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: state_n = RUN;
            RUN: begin
                // count is zero only on the first RUN cycle, where halt may be stale
                if ((count != CW'(0)) && halt) begin
                    halt_fire = 1'b1;
                    state_n   = DONE;
                end else if (count == CW'(TIMEOUT_CYCLES)) begin
                    timeout_fire = 1'b1;
                    state_n      = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        occ_n = occ + OW'(push) - OW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Two-entry request FIFO; a push and pop together only happen at occupancy 1
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            occ       <= OW'(0);
            q_head    <= AW'(0);
            q_tail    <= AW'(0);
            req_ready <= 1'b1;
        end else begin
            occ       <= occ_n;
            req_ready <= (occ_n < OW'(QDEPTH));
            if (push && pop) begin
                q_head <= req_addr;
            end else if (push) begin
                if (occ == OW'(0)) begin
                    q_head <= req_addr;
                end else begin
                    q_tail <= req_addr;
                end
            end else if (pop) begin
                q_head <= q_tail;
            end
        end
    end

    // Run control, cycle counter and result registers
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            start        <= 1'b0;
            start_addr   <= AW'(0);
            busy         <= 1'b0;
            count        <= CW'(0);
            done_valid   <= 1'b0;
            done_addr    <= AW'(0);
            done_cycles  <= CW'(0);
            done_timeout <= 1'b0;
        end else begin
            start      <= (state_n == START);
            busy       <= (state_n != IDLE);
            done_valid <= (state_n == DONE);
            if (pop) begin
                start_addr <= q_head;
            end
            if (state == START) begin
                count <= CW'(0);
            end else if ((state == RUN) && (count != '1)) begin
                count <= count + CW'(1);
            end
            if (halt_fire || timeout_fire) begin
                done_addr    <= start_addr;
                done_cycles  <= count;
                done_timeout <= timeout_fire;
            end
        end
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20000, is the run cycles allowed before a run is aborted.
REQ-002 Parameter QDEPTH, default 2, is the request queue depth in entries; only the value 2 is supported.
REQ-003 CLK  input  1  is the single clock; all state updates occur on the rising edge.
REQ-004 reset_n  input  1  is the reset: synchronous and active-low, sampled on the rising edge of CLK.
REQ-005 req_valid  input  1  indicates a run request is offered.
REQ-006 req_addr  input  8  is the program start address of the offered request.
REQ-007 req_ready  output  1  is high when the queue has a free entry.
REQ-008 start  output  1  is the core start/reset pulse, fed to the core's start input.
REQ-009 start_addr  output  8  is the program start address, fed to the core's start_addr input.
REQ-010 halt  input  1  is the core halt flag.
REQ-011 done_valid  output  1  indicates a run result is presented.
REQ-012 done_ready  input  1  is the consumer acceptance of a presented result.
REQ-013 done_addr  output  8  is the start address of the completed run.
REQ-014 done_cycles  output  16  is the run cycle count.
REQ-015 done_timeout  output  1  is high when the run was aborted by timeout.
REQ-016 busy  output  1  is high in states START, RUN and DONE.

Function
REQ-017 A request is accepted on a cycle with req_valid=1 and req_ready=1; accepted addresses are queued FIFO in a 2-entry queue.
REQ-018 req_ready shall be 1 iff queue occupancy is below 2, computed from registered occupancy with no same-cycle pop bypass.
REQ-019 A simultaneous push and pop shall leave occupancy unchanged and keep FIFO order.
REQ-020 FSM states are IDLE, START, RUN and DONE.
REQ-021 IDLE to START occurs when the queue is non-empty: the head entry is popped into start_addr, and start_addr stays constant until the next pop.
REQ-022 In START, start=1 for exactly one cycle, the cycle counter is cleared to 0, and the FSM moves to RUN; start=0 in all other states.
REQ-023 In RUN, halt shall be ignored on the first RUN cycle, because the core's halt is registered and may be stale from the previous program.
REQ-024 From the second RUN cycle onward, halt=1 moves the FSM to DONE with done_timeout=0.
REQ-025 The cycle counter increments by 1 on every RUN cycle and saturates at 16'hFFFF.
REQ-026 done_cycles equals the number of RUN cycles before halt was sampled high.
REQ-027 When the counter equals TIMEOUT_CYCLES with halt still 0, the FSM moves to DONE with done_timeout=1 and done_cycles=TIMEOUT_CYCLES.
REQ-028 If halt=1 and the timeout condition occur in the same cycle, halt wins and done_timeout=0.
REQ-029 In DONE, done_valid=1 and done_addr, done_cycles and done_timeout are held stable until done_ready=1.
REQ-030 On the DONE handshake, the FSM moves to IDLE; a queued request starts START on the following cycle, giving a minimum of one IDLE cycle between runs.
REQ-031 Requests may be accepted in any state, including during RUN and DONE.
REQ-032 done_ready while done_valid=0 shall be ignored.
REQ-033 Request latency: a request accepted into an empty queue while in IDLE shall see start=1 two cycles after acceptance (queue write, then pop, then START).

Reset
REQ-034 With reset_n=0 at a rising edge, the FSM shall go to IDLE and the queue shall be emptied.
REQ-035 Outputs after reset: start=0, start_addr=0, done_valid=0, done_addr=0, done_cycles=0, done_timeout=0, busy=0, req_ready=1.
REQ-036 Reset asserted mid-run shall abort without producing a result and without a start pulse; the next start occurs only for a request accepted after reset.
REQ-037 Reset takes priority over every simultaneous handshake.

Verification
REQ-038 Single run: push 8'd104, core model asserts halt 50 cycles after start -> one start pulse, start_addr=104, done_cycles=50, done_timeout=0, done_addr=104.
REQ-039 Back-to-back runs: push 0 then 75 while IDLE with done_ready tied 1 -> results appear in order 0 then 75, and req_ready=0 while both entries are held.
REQ-040 Timeout: TIMEOUT_CYCLES=100, halt never asserts -> done_timeout=1, done_cycles=100, busy=1 until done_ready.
REQ-041 Stale halt: halt held 1 entering START -> halt ignored on the first RUN cycle, and done_cycles=1 if halt stays high.
REQ-042 Backpressure: done_ready=0 for 20 cycles with a third request pushed -> outputs stable, no new start pulse, req_ready=0 once queue full, and the next run begins after acceptance.
REQ-043 Reset mid-RUN at cycle 30 -> all outputs return to reset values, queue empty, done_valid never asserted for the aborted run.
